// File: rtl/ace_vram_arbiter.sv
// ace_vram_arbiter
// Shares one single-port screen RAM and one single-port char RAM between the
// Z80 and the video fetch engine. Video normally owns each RAM slot and the
// CPU is held off with wait_n; a starvation counter lets a pending CPU access
// beat video after MAX_WAIT consecutive lost slots.
//
// Ports
//   clk, reset                       clock (clk65), synchronous active-high reset
//   vid_req/vid_sel/vid_addr         video fetch request (held until vid_ack)
//   vid_ack, vid_valid, vid_data     slot grant; read data one cycle after grant
//   cpu_req/sel/we/addr/din          CPU access (held until wait_n=1)
//   cpu_dout, wait_n                 CPU read data (held in C_DONE), Z80 wait
//   ram_addr/din/we/ce_scr/ce_chr    shared RAM port, combinational from slot winner
//   ram_dout_scr, ram_dout_chr       RAM read data (registered inside the RAMs)
module ace_vram_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic              vid_sel,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_valid,
  output logic [7:0]        vid_data,
  input  logic              cpu_req,
  input  logic              cpu_sel,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              wait_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  output logic              ram_ce_scr,
  output logic              ram_ce_chr,
  input  logic [7:0]        ram_dout_scr,
  input  logic [7:0]        ram_dout_chr
);

  typedef enum logic [1:0] {C_IDLE, C_PEND, C_READ, C_DONE} cpu_state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  cpu_state_t state, state_nxt;
  logic [3:0] starve_cnt;
  logic       cpu_pend, starved, cpu_win, vid_win;
  logic       vid_sel_q, cpu_sel_q;

  // Slot arbitration. Nothing is granted while reset is held so a RAM write
  // can never slip through during reset.
  assign cpu_pend = cpu_req && (state == C_IDLE || state == C_PEND);
  assign starved  = cpu_pend && (starve_cnt == MAX_CNT);
  assign vid_win  = !reset && vid_req && !starved;
  assign cpu_win  = !reset && cpu_pend && (starved || !vid_req);

  assign vid_ack = vid_win;

  always_comb begin
    ram_addr   = '0;
    ram_din    = '0;
    ram_we     = 1'b0;
    ram_ce_scr = 1'b0;
    ram_ce_chr = 1'b0;
    if (cpu_win) begin
      ram_addr   = cpu_addr;
      ram_din    = cpu_we ? cpu_din : 8'h00;
      ram_we     = cpu_we;
      ram_ce_scr = !cpu_sel;
      ram_ce_chr = cpu_sel;
    end else if (vid_win) begin
      ram_addr   = vid_addr;
      ram_ce_scr = !vid_sel;
      ram_ce_chr = vid_sel;
    end
  end

  // RAM read data is already registered, so video data is a pure mux on
  // the sel captured with the grant.
  assign vid_data = vid_valid ? (vid_sel_q ? ram_dout_chr : ram_dout_scr) : 8'h00;

  always_comb begin
    state_nxt = state;
    case (state)
      C_IDLE, C_PEND: begin
        if (!cpu_req)     state_nxt = C_IDLE;
        else if (cpu_win) state_nxt = cpu_we ? C_DONE : C_READ;
        else              state_nxt = C_PEND;
      end
      C_READ:  state_nxt = C_DONE;
      C_DONE:  if (!cpu_req) state_nxt = C_IDLE;
      default: state_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= C_IDLE;
      starve_cnt <= '0;
      wait_n     <= 1'b1;
      cpu_dout   <= 8'h00;
      vid_valid  <= 1'b0;
      vid_sel_q  <= 1'b0;
      cpu_sel_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      // wait_n is decoded from the next state so it is low exactly while
      // the FSM sits in C_PEND or C_READ.
      wait_n    <= !(state_nxt == C_PEND || state_nxt == C_READ);
      vid_valid <= vid_win;
      if (vid_win) vid_sel_q <= vid_sel;
      if (cpu_win) cpu_sel_q <= cpu_sel;
      if (state == C_READ)
        cpu_dout <= cpu_sel_q ? ram_dout_chr : ram_dout_scr;
      if (cpu_win || !cpu_pend)
        starve_cnt <= '0;
      else if (starve_cnt != MAX_CNT)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_ace_vram_arbiter.sv
module tb_ace_vram_arbiter;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, vid_req, vid_sel, cpu_req, cpu_sel, cpu_we;
  logic [AW-1:0] vid_addr, cpu_addr, ram_addr;
  logic [7:0]    cpu_din, vid_data, cpu_dout, ram_din, ram_dout_scr, ram_dout_chr;
  logic          vid_ack, vid_valid, wait_n, ram_we, ram_ce_scr, ram_ce_chr;

  ace_vram_arbiter #(.ADDR_W(AW), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_sel(vid_sel), .vid_addr(vid_addr),
    .vid_ack(vid_ack), .vid_valid(vid_valid), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_sel(cpu_sel), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .wait_n(wait_n),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_ce_scr(ram_ce_scr), .ram_ce_chr(ram_ce_chr),
    .ram_dout_scr(ram_dout_scr), .ram_dout_chr(ram_dout_chr)
  );

  function automatic logic [7:0] scr_init(input int i);
    return 8'((i * 5 + 1) & 255);
  endfunction
  function automatic logic [7:0] chr_init(input int i);
    return 8'((i * 3 + 64) & 255);
  endfunction

  // Behavioural single-port RAMs with registered read (old data on write).
  logic [7:0] scr_mem [0:1023];
  logic [7:0] chr_mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) begin
      scr_mem[i] = scr_init(i);
      chr_mem[i] = chr_init(i);
    end
    ram_dout_scr = 8'h00;
    ram_dout_chr = 8'h00;
  end
  always @(posedge clk) begin
    if (ram_ce_scr) begin
      ram_dout_scr <= scr_mem[ram_addr];
      if (ram_we) scr_mem[ram_addr] <= ram_din;
    end
    if (ram_ce_chr) begin
      ram_dout_chr <= chr_mem[ram_addr];
      if (ram_we) chr_mem[ram_addr] <= ram_din;
    end
  end

  typedef struct {
    logic          rst, vr, vs;
    logic [AW-1:0] va;
    logic          cr, cs, cw;
    logic [AW-1:0] ca;
    logic [7:0]    cd;
    logic          e_ack, e_vv;
    logic [7:0]    e_vd;
    logic          e_wn;
    logic [7:0]    e_cd;
    logic          e_we, e_cs, e_cc;
    logic [AW-1:0] e_ad;
    logic [7:0]    e_din;
  } vec_t;

  vec_t vecs [0:63];
  int   nvec   = 0;
  int   passed = 0;
  int   total  = 0;

  task automatic add(input logic rst, vr, vs, input int va,
                     input logic cr, cs, cw, input int ca, input int cd,
                     input logic e_ack, e_vv, input int e_vd, input logic e_wn,
                     input int e_cd, input logic e_we, e_cs, e_cc,
                     input int e_ad, input int e_din);
    vecs[nvec] = '{rst, vr, vs, AW'(va), cr, cs, cw, AW'(ca), 8'(cd),
                   e_ack, e_vv, 8'(e_vd), e_wn, 8'(e_cd), e_we, e_cs, e_cc,
                   AW'(e_ad), 8'(e_din)};
    nvec++;
  endtask

  task automatic chk(input string name, input int row, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
  endtask

  task automatic drive_idle();
    reset = 1'b0; vid_req = 1'b0; vid_sel = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_sel = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = 8'h00;
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // rst vr vs va    cr cs cw ca    cd   | ack vv vd  wn cpu_dout  we cs cc ad    din
    add(1,0,0,0,       0,0,0,0,0,          0,0,0,1,0,            0,0,0,0,0);
    // uncontended write then read back
    add(0,0,0,0,       1,0,1,4,'h5A,       0,0,0,1,0,            1,1,0,4,'h5A);
    add(0,0,0,0,       0,0,0,0,0,          0,0,0,1,0,            0,0,0,0,0);
    add(0,0,0,0,       1,0,0,4,0,          0,0,0,1,0,            0,1,0,4,0);
    add(0,0,0,0,       1,0,0,4,0,          0,0,0,0,0,            0,0,0,0,0);
    add(0,0,0,0,       1,0,0,4,0,          0,0,0,1,'h5A,         0,0,0,0,0);
    add(0,0,0,0,       0,0,0,0,0,          0,0,0,1,'h5A,         0,0,0,0,0);
    // contention: video continuous, CPU read of screen 0x020
    add(0,1,0,'h10,    1,0,0,'h20,0,       1,0,0,1,'h5A,         0,1,0,'h10,0);
    add(0,1,0,'h10,    1,0,0,'h20,0,       1,1,scr_init('h10),0,'h5A, 0,1,0,'h10,0);
    add(0,1,0,'h10,    1,0,0,'h20,0,       1,1,scr_init('h10),0,'h5A, 0,1,0,'h10,0);
    add(0,1,0,'h10,    1,0,0,'h20,0,       1,1,scr_init('h10),0,'h5A, 0,1,0,'h10,0);
    add(0,1,0,'h10,    1,0,0,'h20,0,       0,1,scr_init('h10),0,'h5A, 0,1,0,'h20,0);
    add(0,1,0,'h10,    1,0,0,'h20,0,       1,0,0,0,'h5A,         0,1,0,'h10,0);
    add(0,1,0,'h10,    1,0,0,'h20,0,       1,1,scr_init('h10),1,scr_init('h20), 0,1,0,'h10,0);
    add(0,0,0,0,       0,0,0,0,0,          0,1,scr_init('h10),1,scr_init('h20), 0,0,0,0,0);
    add(0,0,0,0,       0,0,0,0,0,          0,0,0,1,scr_init('h20), 0,0,0,0,0);
    // reset for 3 cycles while in C_READ (char read of 0x005)
    add(0,0,0,0,       1,1,0,5,0,          0,0,0,1,scr_init('h20), 0,0,1,5,0);
    add(1,0,0,0,       1,1,0,5,0,          0,0,0,0,scr_init('h20), 0,0,0,0,0);
    add(1,1,0,'h10,    1,0,1,4,'h99,       0,0,0,1,0,            0,0,0,0,0);
    add(1,1,0,'h10,    1,0,1,4,'h99,       0,0,0,1,0,            0,0,0,0,0);
    add(0,0,0,0,       0,0,0,0,0,          0,0,0,1,0,            0,0,0,0,0);
    // abort from C_PEND: write must never reach the RAM
    add(0,1,0,'h30,    1,0,1,'h30,'hEE,    1,0,0,1,0,            0,1,0,'h30,0);
    add(0,0,0,0,       0,0,0,0,0,          0,1,scr_init('h30),0,0, 0,0,0,0,0);
    add(0,0,0,0,       0,0,0,0,0,          0,0,0,1,0,            0,0,0,0,0);
    add(0,1,0,'h30,    0,0,0,0,0,          1,0,0,1,0,            0,1,0,'h30,0);
    add(0,0,0,0,       0,0,0,0,0,          0,1,scr_init('h30),1,0, 0,0,0,0,0);
    // ordering: CPU write screen 0x100 then video read next slot
    add(0,0,0,0,       1,0,1,'h100,'h77,   0,0,0,1,0,            1,1,0,'h100,'h77);
    add(0,1,0,'h100,   0,0,0,0,0,          1,0,0,1,0,            0,1,0,'h100,0);
    add(0,0,0,0,       0,0,0,0,0,          0,1,'h77,1,0,         0,0,0,0,0);
    add(0,0,0,0,       0,0,0,0,0,          0,0,0,1,0,            0,0,0,0,0);

    for (int r = 0; r < nvec; r++) begin
      @(posedge clk); #1;
      reset = vecs[r].rst;  vid_req = vecs[r].vr;  vid_sel = vecs[r].vs;
      vid_addr = vecs[r].va; cpu_req = vecs[r].cr; cpu_sel = vecs[r].cs;
      cpu_we = vecs[r].cw;  cpu_addr = vecs[r].ca; cpu_din = vecs[r].cd;
      #2;
      chk("vid_ack",    r, int'(vid_ack),    int'(vecs[r].e_ack));
      chk("vid_valid",  r, int'(vid_valid),  int'(vecs[r].e_vv));
      chk("vid_data",   r, int'(vid_data),   int'(vecs[r].e_vd));
      chk("wait_n",     r, int'(wait_n),     int'(vecs[r].e_wn));
      chk("cpu_dout",   r, int'(cpu_dout),   int'(vecs[r].e_cd));
      chk("ram_we",     r, int'(ram_we),     int'(vecs[r].e_we));
      chk("ram_ce_scr", r, int'(ram_ce_scr), int'(vecs[r].e_cs));
      chk("ram_ce_chr", r, int'(ram_ce_chr), int'(vecs[r].e_cc));
      chk("ram_addr",   r, int'(ram_addr),   int'(vecs[r].e_ad));
      chk("ram_din",    r, int'(ram_din),    int'(vecs[r].e_din));
    end

    // back-to-back video stream from char RAM, addresses 0..31
    for (int i = 0; i <= 32; i++) begin
      @(posedge clk); #1;
      drive_idle();
      vid_req  = (i < 32);
      vid_sel  = 1'b1;
      vid_addr = AW'(i);
      #2;
      chk("stream_ack", 100 + i, int'(vid_ack), (i < 32) ? 1 : 0);
      if (i < 32) chk("stream_ce_chr", 100 + i, int'(ram_ce_chr), 1);
      if (i > 0) begin
        chk("stream_valid", 100 + i, int'(vid_valid), 1);
        chk("stream_data",  100 + i, int'(vid_data),  int'(chr_init(i - 1)));
      end
    end

    @(posedge clk); #1;
    drive_idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
